instr_mem_responder: RTL and testbench

Instruction-memory responder for the pipeline's fetch stage: accepts a 16-bit fetch address from the PC side and returns a 20-bit instruction word after a programmable number of wait states. It holds the program image in an internal word array filled through a loader write port. It honours a flush from jump resolution so that stale fetches never reach decode.

---
 rtl/instr_mem_responder.sv | 144 ++++++++++++++
 tb/tb_instr_mem_responder.sv | 249 ++++++++++++++++++++++++
 2 files changed

// File: rtl/instr_mem_responder.sv
// Instruction-memory responder for the fetch stage: loader-filled word array,
// programmable wait states before a one-cycle response, and flush abort.
module instr_mem_responder #(
  parameter int unsigned  DEPTH_LOG2  = 8,
  parameter int unsigned  WAIT_STATES = 1,
  parameter logic [19:0]  NOP_WORD    = 20'h00000
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req_valid,
  input  logic [15:0]           req_addr,
  output logic                  req_ready,
  input  logic                  flush,
  output logic                  rsp_valid,
  output logic [19:0]           rsp_instr,
  output logic [15:0]           rsp_addr,
  output logic                  rsp_err,
  input  logic                  load_en,
  input  logic [DEPTH_LOG2-1:0] load_addr,
  input  logic [19:0]           load_data
);

  localparam int unsigned ADDR_W  = 16;
  localparam int unsigned INSTR_W = 20;
  localparam int unsigned CNT_W   = 4;
  localparam int unsigned DEPTH   = 1 << DEPTH_LOG2;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_RESP = 2'd2
  } state_t;

  state_t               state_q, state_d;
  logic [CNT_W-1:0]     wcnt_q, wcnt_d;
  logic [ADDR_W-1:0]    addr_q, addr_d;
  logic [INSTR_W-1:0]   instr_q, instr_d;
  logic [ADDR_W-1:0]    raddr_q, raddr_d;
  logic                 err_q, err_d;

  logic [INSTR_W-1:0]   mem [DEPTH];
  logic [ADDR_W-1:0]    fetch_addr_c;
  logic                 in_range_c;
  logic [INSTR_W-1:0]   mem_word_c;
  logic                 accept_c;
  logic                 enter_resp_c;

  // Program image: written by the loader regardless of fetch activity, never reset.
  always_ff @(posedge clock) begin
    if (load_en) begin
      mem[load_addr] <= load_data;
    end
  end

  assign req_ready  = reset & ((state_q == S_IDLE) | (state_q == S_RESP)) & ~flush;
  assign rsp_valid  = (state_q == S_RESP) & ~flush;
  assign accept_c   = req_valid & req_ready;
  assign rsp_instr  = instr_q;
  assign rsp_addr   = raddr_q;
  assign rsp_err    = err_q;

  // Address read at RESP entry: the live request for zero wait states, else the latched one.
  assign fetch_addr_c = (state_q == S_WAIT) ? addr_q : req_addr;
  assign in_range_c   = (fetch_addr_c >> DEPTH_LOG2) == '0;
  assign mem_word_c   = mem[fetch_addr_c[DEPTH_LOG2-1:0]];

  // Next-state logic: flush overrides everything, otherwise accept / count / present.
  always_comb begin
    state_d      = state_q;
    wcnt_d       = wcnt_q;
    addr_d       = addr_q;
    enter_resp_c = 1'b0;

    if (flush) begin
      state_d = S_IDLE;
      wcnt_d  = '0;
    end else begin
      case (state_q)
        S_IDLE, S_RESP: begin
          if (accept_c) begin
            addr_d = req_addr;
            if (WAIT_STATES == 0) begin
              state_d      = S_RESP;
              enter_resp_c = 1'b1;
            end else begin
              state_d = S_WAIT;
              wcnt_d  = CNT_W'(WAIT_STATES - 1);
            end
          end else begin
            state_d = S_IDLE;
          end
        end
        S_WAIT: begin
          if (wcnt_q == '0) begin
            state_d      = S_RESP;
            enter_resp_c = 1'b1;
          end else begin
            wcnt_d = wcnt_q - CNT_W'(1);
          end
        end
        default: begin
          state_d = S_IDLE;
          wcnt_d  = '0;
        end
      endcase
    end
  end

  // Response payload is captured only on the RESP-entry edge and held afterwards.
  always_comb begin
    instr_d = instr_q;
    raddr_d = raddr_q;
    err_d   = err_q;
    if (enter_resp_c) begin
      raddr_d = fetch_addr_c;
      if (in_range_c) begin
        instr_d = mem_word_c;
        err_d   = 1'b0;
      end else begin
        instr_d = NOP_WORD;
        err_d   = 1'b1;
      end
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      wcnt_q  <= '0;
      addr_q  <= '0;
      instr_q <= '0;
      raddr_q <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      wcnt_q  <= wcnt_d;
      addr_q  <= addr_d;
      instr_q <= instr_d;
      raddr_q <= raddr_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_instr_mem_responder.sv
// Randomized bench for instr_mem_responder: three instances (0, 1 and 3 wait
// states) share stimulus and are checked against a transaction-level model.
module tb_instr_mem_responder;

  localparam logic [19:0] NOP = 20'h00013;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        req_valid = 1'b0;
  logic [15:0] req_addr = '0;
  logic        flush = 1'b0;
  logic        load_en = 1'b0;
  logic [7:0]  load_addr = '0;
  logic [19:0] load_data = '0;

  logic [2:0]  rdy, vld, err;
  logic [19:0] ins [3];
  logic [15:0] adr [3];

  always #5 clock = ~clock;

  instr_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(0), .NOP_WORD(NOP)) u_dut0 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy[0]), .flush(flush), .rsp_valid(vld[0]), .rsp_instr(ins[0]),
    .rsp_addr(adr[0]), .rsp_err(err[0]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data));

  instr_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(1), .NOP_WORD(NOP)) u_dut1 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy[1]), .flush(flush), .rsp_valid(vld[1]), .rsp_instr(ins[1]),
    .rsp_addr(adr[1]), .rsp_err(err[1]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data));

  instr_mem_responder #(.DEPTH_LOG2(8), .WAIT_STATES(3), .NOP_WORD(NOP)) u_dut3 (
    .clock(clock), .reset(reset), .req_valid(req_valid), .req_addr(req_addr),
    .req_ready(rdy[2]), .flush(flush), .rsp_valid(vld[2]), .rsp_instr(ins[2]),
    .rsp_addr(adr[2]), .rsp_err(err[2]), .load_en(load_en), .load_addr(load_addr),
    .load_data(load_data));

  int tests = 0;
  int errors = 0;

  // Reference: each fetch is a pending transaction that presents a fixed number of edges later.
  int          ws [3] = '{0, 1, 3};
  bit          pend [3];
  int          remain [3];
  logic [15:0] paddr [3];
  bit          pres [3];
  logic [19:0] e_instr [3];
  logic [15:0] e_addr [3];
  logic        e_err [3];
  logic [19:0] mem_m [256];

  int          vcount [3];
  logic [19:0] got_instr [3];
  logic [15:0] got_addr [3];
  logic        got_err [3];

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_clear();
    for (int k = 0; k < 3; k++) begin
      pend[k] = 0; remain[k] = 0; paddr[k] = '0; pres[k] = 0;
      e_instr[k] = '0; e_addr[k] = '0; e_err[k] = 1'b0;
    end
  endtask

  task automatic model_step(input logic rv, input logic [15:0] ra, input logic fl,
                            input logic le, input logic [7:0] la, input logic [19:0] ld);
    for (int k = 0; k < 3; k++) begin
      bit enter;
      logic [15:0] a;
      enter = 0;
      a = '0;
      if (fl) begin
        pend[k] = 0;
        pres[k] = 0;
      end else begin
        if (pend[k]) begin
          remain[k]--;
          if (remain[k] == 0) begin
            pend[k] = 0; enter = 1; a = paddr[k];
          end
        end else if (rv) begin
          if (ws[k] == 0) begin
            enter = 1; a = ra;
          end else begin
            pend[k] = 1; remain[k] = ws[k]; paddr[k] = ra;
          end
        end
        pres[k] = enter;
        if (enter) begin
          e_addr[k] = a;
          if (a < 16'd256) begin
            e_instr[k] = mem_m[a[7:0]]; e_err[k] = 1'b0;
          end else begin
            e_instr[k] = NOP; e_err[k] = 1'b1;
          end
        end
      end
    end
    if (le) mem_m[la] = ld;
  endtask

  task automatic cycle(input logic rv, input logic [15:0] ra, input logic fl,
                       input logic le, input logic [7:0] la, input logic [19:0] ld);
    @(negedge clock);
    req_valid = rv; req_addr = ra; flush = fl;
    load_en = le; load_addr = la; load_data = ld;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("ready_ws%0d", ws[k]), 32'(rdy[k]), 32'(!pend[k] && !fl));
      check($sformatf("valid_ws%0d", ws[k]), 32'(vld[k]), 32'(pres[k] && !fl));
      check($sformatf("instr_ws%0d", ws[k]), 32'(ins[k]), 32'(e_instr[k]));
      check($sformatf("addr_ws%0d", ws[k]), 32'(adr[k]), 32'(e_addr[k]));
      check($sformatf("err_ws%0d", ws[k]), 32'(err[k]), 32'(e_err[k]));
      if (vld[k]) begin
        vcount[k]++;
        got_instr[k] = ins[k]; got_addr[k] = adr[k]; got_err[k] = err[k];
      end
    end
    @(posedge clock);
    model_step(rv, ra, fl, le, la, ld);
  endtask

  task automatic idle(input int n);
    repeat (n) cycle(1'b0, 16'h0, 1'b0, 1'b0, 8'h0, 20'h0);
  endtask

  task automatic fetch(input logic [15:0] a);
    cycle(1'b1, a, 1'b0, 1'b0, 8'h0, 20'h0);
  endtask

  // Asynchronous reset asserted mid-cycle; outputs must collapse before any edge.
  task automatic pulse_reset();
    @(negedge clock);
    #2;
    reset = 1'b0;
    req_valid = 1'b0; flush = 1'b0; load_en = 1'b0;
    #1;
    for (int k = 0; k < 3; k++) begin
      check($sformatf("rst_ready_ws%0d", ws[k]), 32'(rdy[k]), 32'd0);
      check($sformatf("rst_valid_ws%0d", ws[k]), 32'(vld[k]), 32'd0);
      check($sformatf("rst_instr_ws%0d", ws[k]), 32'(ins[k]), 32'd0);
      check($sformatf("rst_addr_ws%0d", ws[k]), 32'(adr[k]), 32'd0);
      check($sformatf("rst_err_ws%0d", ws[k]), 32'(err[k]), 32'd0);
    end
    model_clear();
    repeat (2) @(posedge clock);
    @(negedge clock);
    reset = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL timeout: got running expected finished");
    $fatal(1, "timeout");
  end

  initial begin
    int v0;
    logic [19:0] init_words [4];
    init_words[0] = 20'h11111; init_words[1] = 20'h22222;
    init_words[2] = 20'h33333; init_words[3] = 20'h44444;
    model_clear();
    for (int k = 0; k < 3; k++) vcount[k] = 0;

    #3;
    for (int k = 0; k < 3; k++) begin
      check("init_ready", 32'(rdy[k]), 32'd0);
      check("init_valid", 32'(vld[k]), 32'd0);
      check("init_instr", 32'(ins[k]), 32'd0);
    end
    @(negedge clock);
    reset = 1'b1;

    // Fill the whole image so no fetch ever reads an unwritten word.
    for (int i = 0; i < 256; i++)
      cycle(1'b0, 16'h0, 1'b0, 1'b1, 8'(i), (i < 4) ? init_words[i] : 20'($urandom));

    fetch(16'd2);
    idle(5);
    check("single_instr", 32'(got_instr[1]), 32'h33333);
    check("single_addr", 32'(got_addr[1]), 32'd2);
    check("single_err", 32'(got_err[1]), 32'd0);

    v0 = vcount[0];
    for (int i = 0; i < 4; i++) fetch(16'(i));
    idle(8);
    check("b2b_count", 32'(vcount[0] - v0), 32'd4);
    check("b2b_last", 32'(got_instr[0]), 32'h44444);

    fetch(16'h0F1F);
    idle(5);
    check("oor_instr", 32'(got_instr[1]), 32'(NOP));
    check("oor_err", 32'(got_err[1]), 32'd1);

    idle(2);
    v0 = vcount[2];
    fetch(16'd1);
    cycle(1'b0, 16'h0, 1'b1, 1'b0, 8'h0, 20'h0);
    idle(6);
    check("flush_dropped", 32'(vcount[2] - v0), 32'd0);
    fetch(16'd3);
    idle(5);
    check("after_flush", 32'(got_instr[2]), 32'h44444);

    v0 = vcount[2];
    fetch(16'd0);
    idle(1);
    pulse_reset();
    idle(6);
    check("reset_dropped", 32'(vcount[2] - v0), 32'd0);
    fetch(16'd0);
    idle(5);
    check("mem_retained", 32'(got_instr[2]), 32'h11111);

    cycle(1'b1, 16'd2, 1'b0, 1'b1, 8'd2, 20'hABCDE);
    idle(5);
    check("collide_old", 32'(got_instr[0]), 32'h33333);
    fetch(16'd2);
    idle(5);
    check("collide_new", 32'(got_instr[0]), 32'hABCDE);

    for (int n = 0; n < 600; n++) begin
      logic        rv, fl, le;
      logic [15:0] ra;
      logic [7:0]  la;
      rv = 1'($urandom_range(0, 1));
      ra = ($urandom_range(0, 3) == 0) ? 16'($urandom) : 16'($urandom_range(0, 255));
      fl = ($urandom_range(0, 9) == 0);
      le = ($urandom_range(0, 2) == 0);
      la = ($urandom_range(0, 1) == 1) ? ra[7:0] : 8'($urandom);
      if ($urandom_range(0, 99) == 0) pulse_reset();
      else cycle(rv, ra, fl, le, la, 20'($urandom));
    end
    idle(6);

    $display("End of test - %0d assertions evaluated, %0d failures", tests, errors);
    $finish;
  end

endmodule
